// File: rtl/trb_in_dispatch_if.sv
// ---------------------------------------------------------------------------
// trb_in_dispatch_if
//   Bundles the upstream byte stream and the per-core decoder-side bus of the
//   turbo input dispatcher.
//
//   Upstream stream : st_data_in, st_valid_in, st_sop_in, st_eop_in,
//                     st_ready_out
//   Core side       : trb_data_out (broadcast), trb_valid_out / trb_sop_out /
//                     trb_eop_out (one bit per core), trb_ready_in (per core)
//
//   Modports
//     slave  : the dispatcher. It consumes the stream and drives the cores.
//     master : the environment. It drives the stream and the core readies.
// ---------------------------------------------------------------------------
interface trb_in_dispatch_if #(
  parameter int NUM_TURBO = 2,
  parameter int DW        = 8
);
  logic [DW-1:0]        st_data_in;
  logic                 st_valid_in;
  logic                 st_sop_in;
  logic                 st_eop_in;
  logic                 st_ready_out;

  logic [DW-1:0]        trb_data_out;
  logic [NUM_TURBO-1:0] trb_valid_out;
  logic [NUM_TURBO-1:0] trb_sop_out;
  logic [NUM_TURBO-1:0] trb_eop_out;
  logic [NUM_TURBO-1:0] trb_ready_in;

  modport slave (
    input  st_data_in, st_valid_in, st_sop_in, st_eop_in,
    output st_ready_out,
    output trb_data_out, trb_valid_out, trb_sop_out, trb_eop_out,
    input  trb_ready_in
  );

  modport master (
    output st_data_in, st_valid_in, st_sop_in, st_eop_in,
    input  st_ready_out,
    input  trb_data_out, trb_valid_out, trb_sop_out, trb_eop_out,
    output trb_ready_in
  );
endinterface

// File: rtl/trb_in_dispatch.sv
// ---------------------------------------------------------------------------
// trb_in_dispatch
//   Frame-level round-robin scheduler feeding the turbo decoder array. Whole
//   frames from one byte stream go to cores 0,1,...,NUM_TURBO-1,0,... in
//   strict order, so the output mux (which drains in the same order) keeps
//   frame order end to end. Framing is enforced: a stray non-sop beat
//   between frames is dropped (err_sop), a short frame is closed at its eop
//   (err_len), and a long frame gets a forced eop at FRAME_LEN beats with
//   the remainder discarded up to the upstream eop (err_len).
//
//   Ports
//     clk, rst   : clock, synchronous active-high reset
//     bus        : trb_in_dispatch_if.slave (stream in, per-core bus out)
//     cur_core   : core owning the current frame, or the next one
//     frame_cnt  : frames dispatched, wraps 0xFFFF -> 0
//     err_sop    : one-cycle pulse, sop framing error
//     err_len    : one-cycle pulse, frame length error
// ---------------------------------------------------------------------------
module trb_in_dispatch #(
  parameter int NUM_TURBO = 2,
  parameter int FRAME_LEN = 128,
  parameter int DW        = 8
) (
  input  logic                clk,
  input  logic                rst,
  trb_in_dispatch_if.slave    bus,
  output logic [3:0]          cur_core,
  output logic [15:0]         frame_cnt,
  output logic                err_sop,
  output logic                err_len
);

  localparam logic [10:0] FRAME_LEN_C = 11'(FRAME_LEN);
  localparam logic [3:0]  LAST_CORE   = 4'(NUM_TURBO - 1);

  typedef enum logic [1:0] {SEL, PASS, DROP} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           core_reg, core_next;
  logic [10:0]          cnt_reg, cnt_next;
  logic [15:0]          fcnt_reg, fcnt_next;
  logic [DW-1:0]        data_reg;
  logic [NUM_TURBO-1:0] valid_reg, sop_reg, eop_reg;
  logic [NUM_TURBO-1:0] valid_next, sop_next, eop_next;
  logic                 err_sop_reg, err_sop_next;
  logic                 err_len_reg, err_len_next;

  logic [NUM_TURBO-1:0] core_onehot;
  logic                 ready_sel;
  logic                 st_ready;
  logic                 accept;
  logic                 fwd, fwd_sop, fwd_eop, frame_end;
  logic [10:0]          beat_n;

  // Decode the round-robin pointer once; every per-core signal is gated by it.
  generate
    for (genvar gi = 0; gi < NUM_TURBO; gi++) begin : g_core
      assign core_onehot[gi] = (core_reg == 4'(gi));
      assign valid_next[gi]  = fwd     & core_onehot[gi];
      assign sop_next[gi]    = fwd_sop & core_onehot[gi];
      assign eop_next[gi]    = fwd_eop & core_onehot[gi];
    end
  endgenerate

  // Only the owning core's ready matters: a stalled core stalls the stream
  // rather than being skipped, which keeps the round-robin order intact.
  assign ready_sel = |(bus.trb_ready_in & core_onehot);
  assign st_ready  = rst ? 1'b0 : ((state_reg == DROP) ? 1'b1 : ready_sel);
  assign accept    = bus.st_valid_in & st_ready;

  always_comb begin
    state_next   = state_reg;
    core_next    = core_reg;
    cnt_next     = cnt_reg;
    fcnt_next    = fcnt_reg;
    fwd          = 1'b0;
    fwd_sop      = 1'b0;
    fwd_eop      = 1'b0;
    frame_end    = 1'b0;
    err_sop_next = 1'b0;
    err_len_next = 1'b0;
    beat_n       = cnt_reg + 11'd1;

    case (state_reg)
      SEL: begin
        if (accept) begin
          if (bus.st_sop_in) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
            beat_n  = 11'd1;
          end else begin
            err_sop_next = 1'b1;
          end
        end
      end
      PASS: begin
        if (accept) begin
          fwd = 1'b1;
          // A sop inside a frame is flagged but the beat stays ordinary data.
          if (bus.st_sop_in) err_sop_next = 1'b1;
        end
      end
      DROP: begin
        if (accept && bus.st_eop_in) state_next = SEL;
      end
      default: state_next = SEL;
    endcase

    // Completion rules shared by the first beat (SEL) and mid-frame beats.
    if (fwd) begin
      if (bus.st_eop_in) begin
        fwd_eop      = 1'b1;
        err_len_next = (beat_n != FRAME_LEN_C);
        frame_end    = 1'b1;
        state_next   = SEL;
      end else if (beat_n == FRAME_LEN_C) begin
        // Long frame: close it for the core now, swallow the rest upstream.
        fwd_eop      = 1'b1;
        err_len_next = 1'b1;
        frame_end    = 1'b1;
        state_next   = DROP;
      end else begin
        cnt_next   = beat_n;
        state_next = PASS;
      end
    end

    if (frame_end) begin
      cnt_next  = 11'd0;
      core_next = (core_reg == LAST_CORE) ? 4'd0 : core_reg + 4'd1;
      fcnt_next = fcnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= SEL;
      core_reg    <= 4'd0;
      cnt_reg     <= 11'd0;
      fcnt_reg    <= 16'd0;
      data_reg    <= '0;
      valid_reg   <= '0;
      sop_reg     <= '0;
      eop_reg     <= '0;
      err_sop_reg <= 1'b0;
      err_len_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      core_reg    <= core_next;
      cnt_reg     <= cnt_next;
      fcnt_reg    <= fcnt_next;
      if (fwd) data_reg <= bus.st_data_in;
      valid_reg   <= valid_next;
      sop_reg     <= sop_next;
      eop_reg     <= eop_next;
      err_sop_reg <= err_sop_next;
      err_len_reg <= err_len_next;
    end
  end

  assign bus.st_ready_out  = st_ready;
  assign bus.trb_data_out  = data_reg;
  assign bus.trb_valid_out = valid_reg;
  assign bus.trb_sop_out   = sop_reg;
  assign bus.trb_eop_out   = eop_reg;
  assign cur_core          = core_reg;
  assign frame_cnt         = fcnt_reg;
  assign err_sop           = err_sop_reg;
  assign err_len           = err_len_reg;

endmodule

// File: tb/tb_trb_in_dispatch.sv
`timescale 1ns/1ps
// Testbench for trb_in_dispatch: directed scenarios plus randomized frames,
// with a frame-level reference model feeding an expected-beat queue and an
// independent monitor that checks every beat the cores receive.
module tb_trb_in_dispatch;
  localparam int NT = 2;
  localparam int FL = 128;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cur_core;
  logic [15:0] frame_cnt;
  logic        err_sop, err_len;

  trb_in_dispatch_if #(.NUM_TURBO(NT), .DW(DW)) bus ();

  trb_in_dispatch #(.NUM_TURBO(NT), .FRAME_LEN(FL), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .cur_core  (cur_core),
    .frame_cnt (frame_cnt),
    .err_sop   (err_sop),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        core;
    logic [7:0] data;
    bit        sop;
    bit        eop;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int model_core = 0, model_fc = 0;
  int exp_err_sop = 0, exp_err_len = 0;
  int seen_err_sop = 0, seen_err_len = 0;
  bit mon_en = 1'b0;
  bit rand_ready_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: every beat presented to a core must match the queue head.
  initial begin : monitor
    exp_t e;
    logic [NT-1:0] ev;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (err_sop) seen_err_sop++;
        if (err_len) seen_err_len++;
        if (bus.trb_valid_out != '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_out: got valid=%b data=%h with no beat expected",
                     bus.trb_valid_out, bus.trb_data_out);
          end else begin
            e = exp_q.pop_front();
            ev = '0;
            ev[e.core] = 1'b1;
            if (bus.trb_valid_out !== ev || bus.trb_data_out !== e.data ||
                bus.trb_sop_out !== (e.sop ? ev : '0) ||
                bus.trb_eop_out !== (e.eop ? ev : '0)) begin
              errors++;
              $display("FAIL beat_out: got valid=%b data=%h sop=%b eop=%b, expected valid=%b data=%h sop=%0d eop=%0d",
                       bus.trb_valid_out, bus.trb_data_out, bus.trb_sop_out,
                       bus.trb_eop_out, ev, e.data, e.sop, e.eop);
            end
          end
        end else if ((bus.trb_sop_out | bus.trb_eop_out) != '0) begin
          checks++;
          errors++;
          $display("FAIL framing_out: got sop=%b eop=%b, expected none without valid",
                   bus.trb_sop_out, bus.trb_eop_out);
        end
      end
    end
  end

  // Random per-core readiness, biased towards ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en)
        for (int i = 0; i < NT; i++) bus.trb_ready_in[i] = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one beat until accepted; called and returns at posedge+1.
  task automatic send_beat(input logic [7:0] d, input bit s, input bit e,
                           input bit chk_sop, input int core);
    bit rdy;
    int t;
    logic [NT-1:0] ev;
    bus.st_data_in  = d;
    bus.st_sop_in   = s;
    bus.st_eop_in   = e;
    bus.st_valid_in = 1'b1;
    rdy = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      rdy = bus.st_ready_out;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 2000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", t);
        break;
      end
    end
    bus.st_valid_in = 1'b0;
    if (chk_sop && rdy) begin
      ev = '0;
      ev[core] = 1'b1;
      chk("sop_latency", 32'(bus.trb_sop_out), 32'(ev));
    end
  endtask

  task automatic idle(input int n);
    bus.st_valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame-level model: the frame goes whole to the next core in rotation,
  // truncated to FL beats with eop on its last forwarded beat.
  task automatic send_frame(input int len, input int mid_sop, input int gap_pct,
                            input int stall_at, input logic [NT-1:0] stall_val,
                            input int stall_cyc);
    logic [7:0] d[$];
    int nf, c;
    exp_t e;
    nf = (len < FL) ? len : FL;
    c  = model_core;
    for (int i = 0; i < len; i++) d.push_back(8'($urandom));
    for (int i = 1; i <= nf; i++) begin
      e.core = c;
      e.data = d[i-1];
      e.sop  = (i == 1);
      e.eop  = (i == nf);
      exp_q.push_back(e);
    end
    if (len != FL) exp_err_len++;
    if (mid_sop >= 2 && mid_sop <= nf) exp_err_sop++;
    model_core = (model_core + 1) % NT;
    model_fc   = (model_fc + 1) % 65536;
    for (int i = 1; i <= len; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      if (i == stall_at) begin
        bus.st_data_in   = d[i-1];
        bus.st_sop_in    = (i == 1) || (i == mid_sop);
        bus.st_eop_in    = (i == len);
        bus.st_valid_in  = 1'b1;
        bus.trb_ready_in = stall_val;
        repeat (stall_cyc) begin
          @(negedge clk);
          chk("stall_ready", 32'(bus.st_ready_out), 32'd0);
          @(posedge clk);
          #1;
        end
        bus.trb_ready_in = '1;
      end
      send_beat(d[i-1], (i == 1) || (i == mid_sop), (i == len), (i == 1), c);
    end
  endtask

  task automatic send_stray();
    exp_err_sop++;
    send_beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
  endtask

  task automatic checkpoint(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_cur_core"}, 32'(cur_core), 32'(model_core));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(model_fc));
    chk({tag, "_err_sop_pulses"}, 32'(seen_err_sop), 32'(exp_err_sop));
    chk({tag, "_err_len_pulses"}, 32'(seen_err_len), 32'(exp_err_len));
  endtask

  task automatic stop_random_ready();
    rand_ready_en = 1'b0;
    @(posedge clk);
    #1;
    bus.trb_ready_in = '1;
  endtask

  initial begin : stim
    exp_t e;
    int r, len, mid;
    logic [7:0] d;
    rst = 1'b1;
    bus.st_data_in = '0;
    bus.st_valid_in = 1'b0;
    bus.st_sop_in = 1'b0;
    bus.st_eop_in = 1'b0;
    bus.trb_ready_in = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_st_ready", 32'(bus.st_ready_out), 32'd0);
    chk("rst_valid", 32'(bus.trb_valid_out), 32'd0);
    chk("rst_sop_eop", 32'(bus.trb_sop_out | bus.trb_eop_out), 32'd0);
    chk("rst_cur_core", 32'(cur_core), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'({err_sop, err_len}), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Four full frames back to back, all cores ready.
    repeat (4) send_frame(FL, 0, 0, 0, '0, 0);
    checkpoint("four_frames");

    // One frame with random readiness, then core 1 stalled at a pending sop.
    rand_ready_en = 1'b1;
    send_frame(FL, 0, 10, 0, '0, 0);
    stop_random_ready();
    send_frame(FL, 0, 0, 1, 2'b01, 20);
    checkpoint("core1_stall");

    // Core 0 drops ready for 5 cycles at beat 60.
    send_frame(FL, 0, 0, 60, 2'b10, 5);
    checkpoint("mid_stall");

    // Short frame, long frame, then a normal frame.
    send_frame(100, 0, 0, 0, '0, 0);
    checkpoint("short_frame");
    send_frame(FL + 2, 0, 0, 0, '0, 0);
    send_frame(FL, 0, 0, 0, '0, 0);
    checkpoint("long_frame");

    // Stray non-sop beat between frames.
    send_stray();
    checkpoint("stray_beat");

    // Randomized frames, gaps, readiness, stray beats and mid-frame sops.
    rand_ready_en = 1'b1;
    repeat (24) begin
      r   = $urandom_range(0, 9);
      len = (r < 5) ? FL : (r < 8) ? $urandom_range(1, FL - 1) : $urandom_range(FL + 1, FL + 6);
      mid = ($urandom_range(0, 4) == 0) ? $urandom_range(2, len + 1) : 0;
      if ($urandom_range(0, 5) == 0) send_stray();
      send_frame(len, mid, 15, 0, '0, 0);
    end
    stop_random_ready();
    checkpoint("random");

    // Reset in the middle of a frame at beat 50.
    for (int i = 1; i <= 50; i++) begin
      d = 8'($urandom);
      e.core = model_core;
      e.data = d;
      e.sop  = (i == 1);
      e.eop  = 1'b0;
      exp_q.push_back(e);
      send_beat(d, (i == 1), 1'b0, 1'b0, model_core);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(bus.trb_valid_out), 32'd0);
    chk("midrst_st_ready", 32'(bus.st_ready_out), 32'd0);
    chk("midrst_cur_core", 32'(cur_core), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    model_core = 0;
    model_fc   = 0;
    checkpoint("after_reset");
    send_frame(FL, 0, 0, 0, '0, 0);
    checkpoint("post_reset_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trb_in_dispatch.md
Name: trb_in_dispatch

Overview:
- Frame-level round-robin scheduler on the input side of the turbo decoder array.
- Accepts one byte stream of fixed-length turbo frames and hands each whole frame to decoder cores 0,1,...,NUM_TURBO-1, 0,... in strict order.
- The output-side mux drains cores in the same round-robin order, so frame order is preserved end to end.
- Enforces frame framing (sop/eop, length), applies per-core backpressure, and flags malformed input.

Parameters:
NUM_TURBO, 2, number of decoder cores (1..16)
FRAME_LEN, 128, beats per frame (turbo length/8); 2..2047
DW, 8, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
st_data_in  in  DW  upstream data
st_valid_in  in  1  upstream beat valid
st_sop_in  in  1  first beat of frame
st_eop_in  in  1  last beat of frame
st_ready_out  out  1  upstream ready (combinational)
trb_data_out  out  DW  data broadcast to all cores (registered)
trb_valid_out  out  NUM_TURBO  per-core beat valid (registered, one-hot or zero)
trb_sop_out  out  NUM_TURBO  per-core sop
trb_eop_out  out  NUM_TURBO  per-core eop
trb_ready_in  in  NUM_TURBO  per-core ready
cur_core  out  4  round-robin pointer (core owning the current or next frame)
frame_cnt  out  16  frames dispatched, wraps at 0xFFFF->0
err_sop  out  1  one-cycle pulse: framing error on sop
err_len  out  1  one-cycle pulse: length error

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=SEL, cur_core=0, beat count=0, frame_cnt=0.
  - All trb_* outputs 0; err_sop=0, err_len=0.
  - A partial frame in flight is abandoned; no eop is generated for it.
- Accept: a beat is accepted when st_valid_in & st_ready_out.
- st_ready_out:
  - SEL or PASS: trb_ready_in[cur_core].
  - DROP: 1.
  - Held 0 while rst=1.
- Readiness of other cores is ignored; the scheduler never skips a core, even a stalled one.
- Forwarding:
  - A forwarded beat appears on trb_data_out with trb_valid_out[cur_core]=1 on the next cycle (latency 1).
  - Otherwise all trb_valid/sop/eop bits are 0 the next cycle.
  - trb_data_out holds its last value when no beat is forwarded.
- Beat count: 11 bits, number of beats forwarded in the current frame.
- SEL (waiting for a frame start):
  - Accepted beat with sop=1: forward it with trb_sop_out[cur_core]=1; count=1; go to PASS.
  - If eop=1 on that same beat, apply the PASS completion rules with count 1.
  - Accepted beat with sop=0: discard it, pulse err_sop, stay in SEL.
- PASS (mid-frame): for each accepted beat, n = count+1, and the beat is forwarded.
  - sop=1 in PASS: pulse err_sop; the beat is treated as ordinary data (no sop forwarded).
  - eop=1 and n==FRAME_LEN: forward with eop. Frame done.
  - eop=1 and n<FRAME_LEN (short frame): forward with eop, pulse err_len. Frame done.
  - eop=0 and n==FRAME_LEN (long frame): forward with forced eop, pulse err_len, then go to DROP instead of SEL (cur_core still advances).
  - Otherwise count=n.
- Frame done:
  - cur_core advances (NUM_TURBO-1 wraps to 0).
  - frame_cnt increments.
  - count=0; state returns to SEL.
  - All take effect at the same clock edge as the eop beat is registered.
- DROP:
  - Accepted beats are discarded; nothing is forwarded.
  - On an accepted beat with eop=1, go to SEL.
  - No additional err pulses in DROP.
- Every frame dispatched to a core carries exactly one sop and one eop, and at most FRAME_LEN beats.
- Backpressure: trb_ready_in[cur_core] may drop at any cycle. The core tolerates one in-flight registered beat after deasserting ready (FIFO-based, as on the output side), so no skid buffer is required here.
- st_valid_in=0 cycles inside a frame are allowed and do not affect count.
- NUM_TURBO=1: cur_core stays 0; all other rules are unchanged.

Test Plan:
- NUM_TURBO=2, all ready, four 128-beat frames back-to-back -> cores 0,1,0,1 each receive 128 beats; trb_sop_out one cycle after each sop input; eop on beat 128; frame_cnt=4; cur_core=0.
- trb_ready_in=2'b01 while cur_core=1 and a sop is pending -> st_ready_out=0, no beat to core 0; raise bit1 after 20 cycles -> frame goes to core 1 intact.
- Frame to core 0, trb_ready_in[0]=0 for 5 cycles starting at beat 60 -> st_ready_out=0 for those cycles; core 0 still receives exactly 128 beats in order with eop on beat 128.
- Frame with eop on beat 100 -> core receives 100 beats with eop; err_len pulses once for 1 cycle; next frame goes to the next core.
- 130-beat frame -> eop forced on beat 128; beats 129-130 dropped; err_len pulses once; the following 128-beat frame dispatches normally to the next core.
- Idle beat with sop=0 in SEL -> dropped, err_sop=1 for 1 cycle. Assert rst at beat 50 of a frame -> next cycle all trb_valid_out=0, cur_core=0, frame_cnt=0; the next sop goes to core 0.
